ama_riscv_wb_arbiter: RTL and testbench
=======================================

// Module: ama_riscv_wb_arbiter
//
// PURPOSE
// - Shares the single register-file write port (we/addr_d/data_d) between
//   NUM_REQ writeback sources (ALU/pipeline, load unit, multicycle unit, ...).
// - Arbitration is round-robin with valid/ready handshakes.
// - Output is one registered writeback stage; its contents are also exported
//   for forwarding.
// - Holds a pending-write scoreboard so decode can stall on registers that a
//   multicycle op has yet to write.
//
// PARAMETERS
// - NUM_REQ  3   number of writeback requesters (2..8)
// - DATA_W   32  writeback data width
//
// PORTS
// - clk          in   1              clock; all state updates on rising edge
// - rst_n        in   1              asynchronous reset, active low
// - req_valid    in   NUM_REQ        requester i has a writeback pending
// - req_addr     in   NUM_REQ*5      dest reg of requester i (slice [5i+4:5i])
// - req_data     in   NUM_REQ*DATA_W write data of requester i
// - req_ready    out  NUM_REQ        one-hot grant; transfer = valid & ready
// - wb_hold      in   1              1: grant nothing this cycle
// - rf_we        out  1              to reg file we
// - rf_addr      out  5              to reg file addr_d
// - rf_data      out  DATA_W         to reg file data_d
// - sb_set       in   1              multicycle op issued; mark sb_set_addr busy
// - sb_set_addr  in   5              dest reg of the issued op
// - chk_addr_a   in   5              rs1 to check
// - chk_addr_b   in   5              rs2 to check
// - busy_a       out  1              rs1 has a pending write (comb)
// - busy_b       out  1              rs2 has a pending write (comb)
//
// BEHAVIOUR
// - Reset (async, rst_n=0): rr_ptr=0, rf_we=0, rf_addr=0, rf_data=0,
//   scoreboard all 0. Any in-flight grant is discarded.
// - Grant (comb):
//   - If wb_hold=1, req_ready=0.
//   - Else grant the first valid requester scanning rr_ptr, rr_ptr+1, ...
//     (mod NUM_REQ).
//   - req_ready is one-hot or zero; no valid means zero.
//   - req_ready may depend on req_valid. Requesters hold valid/addr/data
//     stable until ready.
// - Pointer: on a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ.
//   Otherwise rr_ptr holds.
// - Output stage, 1-cycle latency:
//   - On transfer, next cycle rf_we=(addr!=0), rf_addr=addr, rf_data=data.
//   - With no transfer, rf_we=0; rf_addr/rf_data hold their last values.
//   - Writes to x0 are accepted (ready=1) but never assert rf_we.
//   - The write port never backpressures; at most one write per cycle.
// - Forwarding: rf_we/rf_addr/rf_data are the forwardable stage. Consumers
//   compare against rf_addr while rf_we=1.
// - Scoreboard: 32-bit vector sb, where bit 0 is constant 0.
//   - Set: sb_set=1 and sb_set_addr!=0 sets the bit at the next edge.
//   - Clear: a write commit (rf_we=1) clears bit rf_addr at the next edge.
//   - Same reg set and cleared in one cycle: set wins (the newer op owns it).
//   - sb_set to x0 is ignored. A clear of a non-busy bit is a no-op.
// - busy_a = sb[chk_addr_a] | (transfer pending this cycle to chk_addr_a by a
//   requester that has sb bit set). busy_b is the same for chk_addr_b.
//   Index 0 always gives 0.
// - Starvation bound: a continuously valid requester is granted within
//   NUM_REQ non-hold cycles.
//
// TESTING
// 1. Reset: rst_n=0 mid-traffic -> all outputs 0 immediately; after release
//    the first grant goes to req0 if valid.
// 2. All 3 valid continuously, addrs 5/6/7, data A/B/C -> grants 0,1,2,0,...
//    rf_we=1 each cycle; rf_addr 5,6,7 one cycle after each grant.
// 3. req1 valid with addr 0, data 0xDEAD -> req_ready[1]=1; next cycle
//    rf_we=0.
// 4. wb_hold=1 for 3 cycles with req2 valid -> req_ready=0 and rf_we=0
//    throughout; the grant goes to req2 the cycle hold drops.
// 5. sb_set addr 10 -> busy_a=1 for chk_addr_a=10. Multicycle requester
//    writes 10 -> busy clears the cycle after rf_we. A same-cycle new
//    sb_set to 10 keeps it busy.
// 6. Random valid patterns for 10k cycles -> scoreboard model matches;
//    no requester waits more than NUM_REQ non-hold cycles.

Source files
------------

// File: rtl/ama_riscv_wb_arbiter.sv
// ama_riscv_wb_arbiter
//   Shares the single register-file write port between NUM_REQ writeback
//   sources using round-robin arbitration. The winning write is registered
//   into one output stage (rf_we/rf_addr/rf_data), which is also the
//   forwardable stage. A 32-entry pending-write scoreboard lets decode stall
//   on registers that a multicycle op has not yet written.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/addr/data   per-requester writeback request (addr slice [5i+4:5i])
//   req_ready             one-hot grant (or zero); transfer = valid & ready
//   wb_hold               suppresses all grants this cycle
//   rf_we/addr/data       registered write to the register file
//   sb_set, sb_set_addr   mark a destination register as pending
//   chk_addr_a/b          source registers to test
//   busy_a/b              combinational pending-write indication
//
// Handshake: a requester raises req_valid and holds valid/addr/data stable
// until it sees req_ready=1 in the same cycle; that cycle is the transfer.
// req_ready is a function of req_valid, rr_ptr and wb_hold only.
module ama_riscv_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*5-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_hold,
  output logic                      rf_we,
  output logic [4:0]                rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  input  logic                      sb_set,
  input  logic [4:0]                sb_set_addr,
  input  logic [4:0]                chk_addr_a,
  input  logic [4:0]                chk_addr_b,
  output logic                      busy_a,
  output logic                      busy_b
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [31:0]       sb_q, sb_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               xfer;
  logic [4:0]         xfer_addr;
  logic [DATA_W-1:0]  xfer_data;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    xfer      = 1'b0;
    idx       = 0;
    if (!wb_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!xfer && req_valid[idx]) begin
          xfer       = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx[PTR_W-1:0];
        end
      end
    end
  end

  assign req_ready = grant;
  assign xfer_addr = req_addr[int'(grant_idx)*5 +: 5];
  assign xfer_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (xfer) begin
      rr_ptr_d  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      // x0 writes complete the handshake but never reach the register file.
      rf_we_d   = (xfer_addr != 5'd0);
      rf_addr_d = xfer_addr;
      rf_data_d = xfer_data;
    end
  end

  // Clear on commit first, then set, so a same-cycle re-issue keeps the bit.
  always_comb begin
    sb_d = sb_q;
    if (rf_we_q) sb_d[rf_addr_q] = 1'b0;
    if (sb_set && (sb_set_addr != 5'd0)) sb_d[sb_set_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      sb_q      <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      sb_q      <= sb_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

  // A register is busy if marked pending, or if the write being granted right
  // now targets it while it is still marked pending.
  assign busy_a = (chk_addr_a != 5'd0) &&
                  (sb_q[chk_addr_a] || (xfer && (xfer_addr == chk_addr_a) && sb_q[xfer_addr]));
  assign busy_b = (chk_addr_b != 5'd0) &&
                  (sb_q[chk_addr_b] || (xfer && (xfer_addr == chk_addr_b) && sb_q[xfer_addr]));

endmodule

// File: tb/tb_ama_riscv_wb_arbiter.sv
module tb_ama_riscv_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int EW = 1 + 5 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wb_hold;
  logic            rf_we;
  logic [4:0]      rf_addr;
  logic [DW-1:0]   rf_data;
  logic            sb_set;
  logic [4:0]      sb_set_addr;
  logic [4:0]      chk_addr_a, chk_addr_b;
  logic            busy_a, busy_b;

  ama_riscv_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0] exp_q[$];
  int            n_total = 0;
  int            n_bad   = 0;
  int            m_ptr;
  logic          m_we;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  logic [31:0]   m_sb;
  int            wait_cnt [N];
  logic [N-1:0]  xfer_vec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_busy(input logic [4:0] a, input logic xf, input logic [4:0] xa);
    return (a != 5'd0) && (m_sb[a] || (xf && xa == a && m_sb[xa]));
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_sb   = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // One cycle: inputs are already driven (just after a negedge).
  task automatic step();
    int            g;
    int            gi;
    logic          xf;
    logic [4:0]    xa;
    logic [DW-1:0] xd;
    logic [N-1:0]  eg;
    logic [EW-1:0] e;
    #1;
    g  = -1;
    eg = '0;
    if (!wb_hold) begin
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (m_ptr + i) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    xf = (g >= 0);
    gi = xf ? g : 0;
    xa = xf ? req_addr[gi*5 +: 5] : 5'd0;
    xd = xf ? req_data[gi*DW +: DW] : '0;
    check("grant", 64'(req_ready), 64'(eg));
    check("busy_a", 64'(busy_a), 64'(exp_busy(chk_addr_a, xf, xa)));
    check("busy_b", 64'(busy_b), 64'(exp_busy(chk_addr_b, xf, xa)));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_we",   64'(rf_we),   64'(e[EW-1]));
      check("rf_addr", 64'(rf_addr), 64'(e[EW-2 -: 5]));
      check("rf_data", 64'(rf_data), 64'(e[DW-1:0]));
    end
    // starvation bound: at most N-1 non-hold cycles lost before a grant
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i]) wait_cnt[i] = 0;
      else if (!wb_hold) begin
        if (g == i) begin
          check("starve_ok", 64'(wait_cnt[i] < N), 64'd1);
          wait_cnt[i] = 0;
        end else wait_cnt[i]++;
      end
    end
    // next-state model
    e = {xf && (xa != 5'd0), xf ? xa : m_addr, xf ? xd : m_data};
    exp_q.push_back(e);
    if (m_we) m_sb[m_addr] = 1'b0;
    if (sb_set && sb_set_addr != 5'd0) m_sb[sb_set_addr] = 1'b1;
    m_we   = e[EW-1];
    m_addr = e[EW-2 -: 5];
    m_data = e[DW-1:0];
    if (xf) m_ptr = (g + 1) % N;
    xfer_vec = eg;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [DW-1:0] d);
    req_valid[i]       = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    wb_hold     = 1'b0;
    sb_set      = 1'b0;
    sb_set_addr = '0;
    chk_addr_a  = '0;
    chk_addr_b  = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    xfer_vec = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();                                   // reset state of the output stage

    // round-robin with all three valid
    set_req(0, 1'b1, 5'd5, 32'hAAAA_0001);
    set_req(1, 1'b1, 5'd6, 32'hBBBB_0002);
    set_req(2, 1'b1, 5'd7, 32'hCCCC_0003);
    chk_addr_a = 5'd5;
    chk_addr_b = 5'd7;
    repeat (7) step();

    // asynchronous reset in the middle of traffic
    #2 rst_n = 1'b0;
    #1;
    check("rst_rf_we",   64'(rf_we),   64'd0);
    check("rst_rf_addr", 64'(rf_addr), 64'd0);
    check("rst_rf_data", 64'(rf_data), 64'd0);
    check("rst_busy_a",  64'(busy_a),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();                                   // first grant after release: req0
    check("rst_first_grant", 64'(xfer_vec), 64'b001);
    step();

    // write to x0: accepted, no rf_we
    clear_inputs();
    set_req(1, 1'b1, 5'd0, 32'h0000_DEAD);
    step();
    check("x0_ready", 64'(xfer_vec), 64'b010);
    clear_inputs();
    step();

    // hold for three cycles with req2 pending
    set_req(2, 1'b1, 5'd9, 32'h1234_5678);
    wb_hold = 1'b1;
    repeat (3) step();
    wb_hold = 1'b0;
    step();
    check("hold_release_grant", 64'(xfer_vec), 64'b100);
    clear_inputs();
    step();

    // scoreboard: set, commit clears, same-cycle re-set keeps busy
    chk_addr_a = 5'd10;
    chk_addr_b = 5'd11;
    sb_set = 1'b1; sb_set_addr = 5'd10;
    step();
    sb_set = 1'b0;
    step();
    set_req(2, 1'b1, 5'd10, 32'h0000_0A0A);
    step();                                   // transfer of the pending write
    set_req(2, 1'b0, 5'd0, 32'h0);
    step();                                   // rf_we=1, still busy
    step();                                   // cleared
    sb_set = 1'b1; sb_set_addr = 5'd10;
    step();
    sb_set = 1'b0;
    set_req(0, 1'b1, 5'd10, 32'h0000_0B0B);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    sb_set = 1'b1; sb_set_addr = 5'd10;       // re-issue during the commit cycle
    step();
    sb_set = 1'b0;
    repeat (2) step();                        // must remain busy
    sb_set = 1'b1; sb_set_addr = 5'd0;        // x0 never becomes busy
    chk_addr_a = 5'd0;
    step();
    clear_inputs();
    step();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (xfer_vec[i] || !req_valid[i])
          set_req(i, ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 15)), $urandom());
      end
      wb_hold     = ($urandom_range(0, 9) == 0);
      sb_set      = ($urandom_range(0, 9) < 2);
      sb_set_addr = 5'($urandom_range(0, 15));
      chk_addr_a  = 5'($urandom_range(0, 15));
      chk_addr_b  = 5'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
